mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares one sram-like memory bus between the pipeline's instruction-fetch port (pcF/instrF side) and data port (M-stage load/store side). Each side issues a level request and gets a single-cycle acknowledge with read data. A three-state FSM sequences the bus address and data handshakes, and a combinational stall request tells the hazard unit to freeze the pipeline until every pending access is acknowledged.

## Interface
- AW, default 32, address width
- DW, default 32, data width
---
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- inst_req  in  1  fetch request; level, held until inst_ack
- inst_addr  in  AW  fetch address
- inst_rdata  out  DW  fetch data; valid with inst_ack, held afterwards
- inst_ack  out  1  one-cycle fetch completion
- data_req  in  1  load/store request; level, held until data_ack
- data_wr  in  1  1 = store
- data_wstrb  in  4  byte enables, memwriteM encoding
- data_addr  in  AW  load/store address
- data_wdata  in  DW  store data
- data_rdata  out  DW  load data; valid with data_ack, held afterwards
- data_ack  out  1  one-cycle load/store completion
- flush  in  1  exception/eret redirect: cancel the in-flight fetch result
- stall_req  out  1  to hazard unit: an access is pending
- bus_req, bus_wr  out  1  bus request, write flag
- bus_wstrb  out  4  bus byte enables
- bus_addr  out  AW ; bus_wdata  out  DW
- bus_addr_ok, bus_data_ok  in  1  bus handshakes
- bus_rdata  in  DW  bus read data

## Operation
- FSM states: IDLE, ADDR, DATA. A 1-bit owner register records the granted side (I or D).
- **IDLE**
  - If data_req is high, grant D.
  - Otherwise, if inst_req is high and flush is low, grant I.
  - On a grant: latch addr/wr/wstrb/wdata into bus registers and go to ADDR.
  - An inst grant always latches wr=0 and wstrb=0.
- **ADDR**
  - bus_req=1; bus_* outputs come from the latched registers, so requester changes are ignored.
  - On bus_addr_ok, go to DATA.
  - bus_req is never withdrawn early, even on flush.
- **DATA**
  - bus_req=0.
  - On bus_data_ok, pulse the owner's ack combinationally in the same cycle and return to IDLE.
  - For loads, the owner's rdata output passes bus_rdata through that cycle and latches it for later cycles.
  - For stores, data_rdata is unchanged.
- **Cancel**
  - flush in ADDR or DATA while owner=I sets a cancel flag.
  - With cancel set (or flush high in the data_ok cycle), inst_ack is suppressed and inst_rdata is not updated.
  - Cancel clears on return to IDLE.
  - Data transactions ignore flush.
- stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack).
- Requesters may change or drop req on the edge after their ack. The IDLE re-arbitration happens after that edge, so no duplicate grant occurs.

## Timing
- Reset values:
  - state IDLE, owner I, cancel 0
  - bus_req, bus_wr, inst_ack, data_ack all 0
  - bus_wstrb, bus_addr, bus_wdata, inst_rdata, data_rdata all 0
- Minimum transaction is 3 cycles:
  - t0: IDLE samples req
  - t1: ADDR, bus_addr_ok=1
  - t2: DATA, bus_data_ok=1 and ack=1
  - t3: IDLE
- Each cycle of addr_ok or data_ok delay adds one cycle.
- Back-to-back: the second grant occurs in the IDLE cycle after the first ack (t3), giving a 3-cycle throughput.
- Simultaneous inst_req and data_req in IDLE: D first (default policy), I at the next IDLE.
- flush in the same IDLE cycle as inst_req: no grant that cycle. The fetch is re-requested at the redirected address.
- Reset asserted mid-transaction: immediate return to reset values. Bus-side recovery is the bus owner's concern.

## Configuration
- Macro: MEM_BUS_ARBITER_FAIR_EN.
- Defined: a last-served bit (reset = I) is updated on each ack. When both sides request in IDLE, the side not served last wins, so sides alternate under contention.
- Undefined: data always wins. The last-served bit is not implemented.

## Test plan
- **Single fetch.** inst_req=1, inst_addr=0xbfc00000, bus ready immediately, bus_rdata=0x24080001 -> bus_req=1 on t1 with bus_addr=0xbfc00000; inst_ack=1 and inst_rdata=0x24080001 on t2; stall_req=0 from t3.
- **Store with delayed handshake.** data_req=1, wr=1, wstrb=4'b0011, addr=0x80001000, wdata=0xdeadbeef, addr_ok after 2 cycles, data_ok after 3 -> bus_req held 3 cycles, data_ack 7 cycles after request, data_rdata unchanged.
- **Contention, default build.** Both requests at t0 -> data transaction first (ack t2), fetch granted t3 (ack t5).
  - With MEM_BUS_ARBITER_FAIR_EN and a repeated load/fetch stream: grants alternate D, I, D, I.
- **Flush in DATA.** Flush during an inst DATA phase, data_ok 1 cycle later -> inst_ack stays 0, inst_rdata keeps its old value, FSM returns to IDLE. A new inst_req to 0xbfc00380 is then granted normally.
- **Flush during a load.** Flush while owner=D -> data_ack still pulses and load data is delivered.
- **Reset mid-transaction.** rst asserted while in ADDR -> bus_req=0 and all outputs 0 in the same cycle. After release, a pending inst_req is granted from IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like memory bus shared by fetch and load/store traffic.
// master = arbiter side (drives request/address/data), slave = memory side.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          bus_req;
   logic          bus_wr;
   logic [3:0]    bus_wstrb;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_addr_ok;
   logic          bus_data_ok;
   logic [DW-1:0] bus_rdata;

   modport master (
      output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport slave (
      input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one SRAM-like bus (IDLE/ADDR/DATA).
// Define MEM_BUS_ARBITER_FAIR_EN to alternate sides under contention; default lets data win.
module mem_bus_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inst_req,
   input  logic [AW-1:0]        inst_addr,
   output logic [DW-1:0]        inst_rdata,
   output logic                 inst_ack,
   input  logic                 data_req,
   input  logic                 data_wr,
   input  logic [3:0]           data_wstrb,
   input  logic [AW-1:0]        data_addr,
   input  logic [DW-1:0]        data_wdata,
   output logic [DW-1:0]        data_rdata,
   output logic                 data_ack,
   input  logic                 flush,
   output logic                 stall_req,
   mem_bus_arbiter_if.master    bus
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t        state_q;
   logic          owner_q;
   logic          cancel_q;
   logic          bus_req_q;
   logic          bus_wr_q;
   logic [3:0]    bus_wstrb_q;
   logic [AW-1:0] bus_addr_q;
   logic [DW-1:0] bus_wdata_q;
   logic [DW-1:0] inst_rdata_q;
   logic [DW-1:0] data_rdata_q;

   logic inst_ok;
   logic grant_d;
   logic grant_i;
   logic xfer_done;

   // A fetch raised together with flush targets a stale PC, so it is not eligible.
   assign inst_ok = inst_req & ~flush;

`ifdef MEM_BUS_ARBITER_FAIR_EN
   logic last_d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d_q <= OWN_I;
      end else if (data_ack) begin
         last_d_q <= OWN_D;
      end else if (inst_ack) begin
         last_d_q <= OWN_I;
      end
   end

   assign grant_d = data_req & (~inst_ok | (last_d_q == OWN_I));
`else
   assign grant_d = data_req;
`endif

   assign grant_i   = inst_ok & ~grant_d;
   assign xfer_done = (state_q == DATA) & bus.bus_data_ok;

   assign inst_ack  = xfer_done & (owner_q == OWN_I) & ~cancel_q & ~flush;
   assign data_ack  = xfer_done & (owner_q == OWN_D);

   assign inst_rdata = inst_ack ? bus.bus_rdata : inst_rdata_q;
   assign data_rdata = (data_ack & ~bus_wr_q) ? bus.bus_rdata : data_rdata_q;

   assign stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack);

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_wr    = bus_wr_q;
   assign bus.bus_wstrb = bus_wstrb_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_I;
         cancel_q     <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_wstrb_q  <= '0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d | grant_i) begin
                  state_q     <= ADDR;
                  bus_req_q   <= 1'b1;
                  owner_q     <= grant_d ? OWN_D : OWN_I;
                  bus_addr_q  <= grant_d ? data_addr : inst_addr;
                  bus_wr_q    <= grant_d & data_wr;
                  bus_wstrb_q <= grant_d ? data_wstrb : 4'b0000;
                  bus_wdata_q <= grant_d ? data_wdata : '0;
               end
            end
            ADDR: begin
               if (flush && owner_q == OWN_I) begin
                  cancel_q <= 1'b1;
               end
               if (bus.bus_addr_ok) begin
                  state_q   <= DATA;
                  bus_req_q <= 1'b0;
               end
            end
            DATA: begin
               if (flush && owner_q == OWN_I) begin
                  cancel_q <= 1'b1;
               end
               if (bus.bus_data_ok) begin
                  state_q  <= IDLE;
                  cancel_q <= 1'b0;
                  if (inst_ack) begin
                     inst_rdata_q <= bus.bus_rdata;
                  end
                  if (data_ack && !bus_wr_q) begin
                     data_rdata_q <= bus.bus_rdata;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               bus_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, delayed store, contention, flush cases, async reset.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic [31:0] inst_rdata;
   logic        inst_ack;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [3:0]  data_wstrb = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [31:0] data_rdata;
   logic        data_ack;
   logic        flush = 1'b0;
   logic        stall_req;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_if ();

   mem_bus_arbiter #(.AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_ack   (inst_ack),
      .data_req   (data_req),
      .data_wr    (data_wr),
      .data_wstrb (data_wstrb),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_ack   (data_ack),
      .flush      (flush),
      .stall_req  (stall_req),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      bus_if.bus_addr_ok = 1'b0;
      bus_if.bus_data_ok = 1'b0;
      bus_if.bus_rdata   = '0;

      // Reset state
      smp();
      check("rst_bus_req", bus_if.bus_req, 1'b0);
      check("rst_bus_wr", bus_if.bus_wr, 1'b0);
      check("rst_bus_addr", bus_if.bus_addr, 32'h0);
      check("rst_inst_ack", inst_ack, 1'b0);
      check("rst_data_ack", data_ack, 1'b0);
      check("rst_inst_rdata", inst_rdata, 32'h0);
      check("rst_data_rdata", data_rdata, 32'h0);
      check("rst_stall", stall_req, 1'b0);
      step();
      rst = 1'b0;
      step();

      // Single fetch, bus ready immediately
      inst_req = 1'b1; inst_addr = 32'hbfc00000;
      bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h24080001;
      smp();
      check("f_t0_stall", stall_req, 1'b1);
      check("f_t0_bus_req", bus_if.bus_req, 1'b0);
      step();
      smp();
      check("f_t1_bus_req", bus_if.bus_req, 1'b1);
      check("f_t1_bus_addr", bus_if.bus_addr, 32'hbfc00000);
      check("f_t1_bus_wr", bus_if.bus_wr, 1'b0);
      check("f_t1_bus_wstrb", bus_if.bus_wstrb, 4'b0000);
      step();
      smp();
      check("f_t2_inst_ack", inst_ack, 1'b1);
      check("f_t2_inst_rdata", inst_rdata, 32'h24080001);
      check("f_t2_stall", stall_req, 1'b0);
      check("f_t2_bus_req", bus_if.bus_req, 1'b0);
      step();
      inst_req = 1'b0; bus_if.bus_rdata = 32'h0;
      smp();
      check("f_t3_inst_ack", inst_ack, 1'b0);
      check("f_t3_inst_rdata", inst_rdata, 32'h24080001);
      check("f_t3_stall", stall_req, 1'b0);
      check("f_t3_bus_req", bus_if.bus_req, 1'b0);
      $display("txn fetch bfc00000 done");
      step();

      // Contention: data (load) first, then the fetch
      inst_req = 1'b1; inst_addr = 32'hbfc00010;
      data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'b0000; data_addr = 32'h80002000;
      smp();
      check("c_t0_stall", stall_req, 1'b1);
      step();
      smp();
      check("c_t1_bus_addr", bus_if.bus_addr, 32'h80002000);
      check("c_t1_bus_wr", bus_if.bus_wr, 1'b0);
      step();
      bus_if.bus_rdata = 32'haaaa0001;
      smp();
      check("c_t2_data_ack", data_ack, 1'b1);
      check("c_t2_inst_ack", inst_ack, 1'b0);
      check("c_t2_data_rdata", data_rdata, 32'haaaa0001);
      check("c_t2_stall", stall_req, 1'b1);
      step();
      data_req = 1'b0;
      smp();
      check("c_t3_bus_req", bus_if.bus_req, 1'b0);
      check("c_t3_data_ack", data_ack, 1'b0);
      check("c_t3_stall", stall_req, 1'b1);
      step();
      smp();
      check("c_t4_bus_req", bus_if.bus_req, 1'b1);
      check("c_t4_bus_addr", bus_if.bus_addr, 32'hbfc00010);
      step();
      bus_if.bus_rdata = 32'hbbbb0002;
      smp();
      check("c_t5_inst_ack", inst_ack, 1'b1);
      check("c_t5_inst_rdata", inst_rdata, 32'hbbbb0002);
      check("c_t5_data_rdata", data_rdata, 32'haaaa0001);
      step();
      inst_req = 1'b0;
      $display("txn contention load 80002000 then fetch bfc00010 done");
      step();

      // Store with addr_ok delayed 2 cycles and data_ok delayed 3 cycles
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
      data_addr = 32'h80001000; data_wdata = 32'hdeadbeef;
      bus_if.bus_rdata = 32'h11111111;
      for (int k = 0; k < 8; k++) begin
         bus_if.bus_addr_ok = (k == 3);
         bus_if.bus_data_ok = (k == 7);
         if (k == 2) data_addr = 32'h12345678;
         smp();
         check($sformatf("s_k%0d_bus_req", k), bus_if.bus_req, (k >= 1 && k <= 3));
         check($sformatf("s_k%0d_data_ack", k), data_ack, (k == 7));
         if (k == 1) begin
            check("s_bus_wr", bus_if.bus_wr, 1'b1);
            check("s_bus_wstrb", bus_if.bus_wstrb, 4'b0011);
            check("s_bus_wdata", bus_if.bus_wdata, 32'hdeadbeef);
         end
         if (k == 3) check("s_bus_addr_latched", bus_if.bus_addr, 32'h80001000);
         if (k == 7) check("s_data_rdata_held", data_rdata, 32'haaaa0001);
         step();
      end
      data_req = 1'b0; data_wr = 1'b0;
      smp();
      check("s_after_data_ack", data_ack, 1'b0);
      $display("txn store 80001000 <= deadbeef done");
      step();

      // Flush during the DATA phase of a fetch
      inst_req = 1'b1; inst_addr = 32'hbfc00020;
      bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b0;
      step();
      smp();
      check("x_t1_bus_req", bus_if.bus_req, 1'b1);
      step();
      flush = 1'b1;
      smp();
      check("x_t2_inst_ack", inst_ack, 1'b0);
      check("x_t2_bus_req", bus_if.bus_req, 1'b0);
      step();
      flush = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hcccc0003;
      smp();
      check("x_t3_inst_ack", inst_ack, 1'b0);
      check("x_t3_inst_rdata", inst_rdata, 32'hbbbb0002);
      check("x_t3_stall", stall_req, 1'b1);
      step();
      inst_addr = 32'hbfc00380; flush = 1'b1;
      smp();
      check("x_t4_bus_req", bus_if.bus_req, 1'b0);
      check("x_t4_inst_rdata", inst_rdata, 32'hbbbb0002);
      step();
      flush = 1'b0;
      smp();
      check("x_t5_no_grant", bus_if.bus_req, 1'b0);
      step();
      smp();
      check("x_t6_bus_req", bus_if.bus_req, 1'b1);
      check("x_t6_bus_addr", bus_if.bus_addr, 32'hbfc00380);
      step();
      bus_if.bus_rdata = 32'hdddd0004;
      smp();
      check("x_t7_inst_ack", inst_ack, 1'b1);
      check("x_t7_inst_rdata", inst_rdata, 32'hdddd0004);
      step();
      inst_req = 1'b0;
      $display("txn fetch bfc00020 cancelled, refetch bfc00380 done");
      step();

      // Flush during a load has no effect on the data side
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80003000; flush = 1'b1;
      bus_if.bus_rdata = 32'heeee0005;
      step();
      smp();
      check("l_t1_bus_req", bus_if.bus_req, 1'b1);
      check("l_t1_bus_addr", bus_if.bus_addr, 32'h80003000);
      step();
      smp();
      check("l_t2_data_ack", data_ack, 1'b1);
      check("l_t2_data_rdata", data_rdata, 32'heeee0005);
      step();
      data_req = 1'b0; flush = 1'b0;
      $display("txn load 80003000 under flush done");
      step();

      // Asynchronous reset while in ADDR
      inst_req = 1'b1; inst_addr = 32'hbfc00040;
      bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
      step();
      smp();
      check("r_addr_bus_req", bus_if.bus_req, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("r_async_bus_req", bus_if.bus_req, 1'b0);
      check("r_async_bus_addr", bus_if.bus_addr, 32'h0);
      check("r_async_inst_rdata", inst_rdata, 32'h0);
      check("r_async_data_rdata", data_rdata, 32'h0);
      step();
      rst = 1'b0; bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1;
      smp();
      check("r_idle_bus_req", bus_if.bus_req, 1'b0);
      step();
      smp();
      check("r_grant_bus_req", bus_if.bus_req, 1'b1);
      check("r_grant_bus_addr", bus_if.bus_addr, 32'hbfc00040);
      step();
      bus_if.bus_rdata = 32'h12345678;
      smp();
      check("r_inst_ack", inst_ack, 1'b1);
      check("r_inst_rdata", inst_rdata, 32'h12345678);
      step();
      inst_req = 1'b0;
      $display("txn reset mid-fetch, refetch bfc00040 done");
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
